decod_mem_seq: RTL and testbench

- Parametrised, sequenced successor to the 4-to-16 memory word decoder.
- Decodes an ADDR_W-bit address into a registered one-hot select over NUM_WORDS lines.
- Wraps each access in a req/ack transaction: address setup, then a timed read or write strobe, then acknowledge.
- Sits between the Neander control unit and the memory word array. Out-of-range addresses are flagged instead of silently selecting nothing.

---
 rtl/decod_mem_seq_if.sv | 44 ++++
 rtl/decod_mem_seq.sv | 156 +++++++++++++++
 tb/tb_decod_mem_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decod_mem_seq_if.sv
// rtl/decod_mem_seq_if.sv - req/ack access bus between control unit and word decoder
//
// Purpose: bundles the request side (req, we, addr) driven by the control
// unit and the select/strobe/ack side driven by the sequenced decoder.
//
// Signals:
//   req        access request, sampled by the decoder only while idle
//   we         1 = write, 0 = read, captured with req
//   addr       word address, captured with req
//   sel        registered one-hot word select (or all zero)
//   wr_strobe  write pulse to the selected word
//   rd_strobe  read-enable pulse to the selected word
//   ack        one-cycle transaction-complete pulse
//   err        out-of-range flag, meaningful only while ack is high
//   busy       decoder is inside a transaction
//
// Modports:
//   master  control-unit side (drives req/we/addr)
//   slave   decoder side (drives sel/strobes/ack/err/busy)

interface decod_mem_seq_if #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
);
    logic                 req;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [NUM_WORDS-1:0] sel;
    logic                 wr_strobe;
    logic                 rd_strobe;
    logic                 ack;
    logic                 err;
    logic                 busy;

    modport master (
        output req, we, addr,
        input  sel, wr_strobe, rd_strobe, ack, err, busy
    );

    modport slave (
        input  req, we, addr,
        output sel, wr_strobe, rd_strobe, ack, err, busy
    );
endinterface

// File: rtl/decod_mem_seq.sv
// rtl/decod_mem_seq.sv - sequenced address decoder with timed read/write strobes
//
// Purpose: decodes an ADDR_W-bit word address into a registered one-hot
// select over NUM_WORDS lines and wraps every access in a req/ack
// transaction: one cycle of address setup, a read or write strobe lasting
// PULSE_LEN cycles, then a one-cycle ack. Addresses at or above NUM_WORDS
// are answered immediately with ack+err and never drive a select line.
//
// Parameters:
//   ADDR_W     address width in bits (1..8)
//   NUM_WORDS  implemented words / select lines (1..2**ADDR_W)
//   PULSE_LEN  strobe width in clock cycles (1..15)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    decod_mem_seq_if.slave: req/we/addr in; sel, wr_strobe,
//          rd_strobe, ack, err, busy out (all registered)

module decod_mem_seq #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16,
    parameter int PULSE_LEN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    decod_mem_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        DONE     = 3'd3,
        DONE_ERR = 3'd4
    } state_t;

    localparam int unsigned NW_U      = NUM_WORDS;
    localparam logic [3:0]  CNT_LOAD  = 4'(PULSE_LEN - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [NUM_WORDS-1:0] sel_q, sel_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 in_range;

    // Zero-extend the address to 32 bits so the range test is a plain
    // unsigned compare regardless of ADDR_W.
    assign in_range = ({{(32-ADDR_W){1'b0}}, bus.addr} < NW_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.req) begin
                    if (in_range) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            sel_d[i] = (bus.addr == ADDR_W'(i));
                        end
                        we_d    = bus.we;
                        state_d = SETUP;
                    end else begin
                        // Out of range: answer at once, no select, no strobe.
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE_ERR;
                    end
                end
            end

            SETUP: begin
                cnt_d   = CNT_LOAD;
                wr_d    = we_q;
                rd_d    = ~we_q;
                state_d = STROBE;
            end

            STROBE: begin
                // Counter holds the number of strobe cycles still to come
                // after the current one; at zero the strobe ends here.
                if (cnt_q == 4'd0) begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    wr_d  = wr_q;
                    rd_d  = rd_q;
                end
            end

            DONE: begin
                sel_d   = '0;
                state_d = IDLE;
            end

            DONE_ERR: begin
                sel_d   = '0;
                state_d = IDLE;
            end

            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase

        // busy is registered alongside the state so it is low exactly in IDLE.
        busy_d = (state_d != IDLE);
    end

    assign bus.sel       = sel_q;
    assign bus.wr_strobe = wr_q;
    assign bus.rd_strobe = rd_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_decod_mem_seq.sv
// tb/tb_decod_mem_seq.sv - self-checking bench for decod_mem_seq

module tb_decod_mem_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       we;
    logic [3:0] addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decod_mem_seq_if #(.ADDR_W(4), .NUM_WORDS(16)) bus_a ();
    decod_mem_seq_if #(.ADDR_W(4), .NUM_WORDS(12)) bus_b ();
    decod_mem_seq_if #(.ADDR_W(4), .NUM_WORDS(16)) bus_c ();

    assign bus_a.req = req;  assign bus_a.we = we;  assign bus_a.addr = addr;
    assign bus_b.req = req;  assign bus_b.we = we;  assign bus_b.addr = addr;
    assign bus_c.req = req;  assign bus_c.we = we;  assign bus_c.addr = addr;

    decod_mem_seq #(.ADDR_W(4), .NUM_WORDS(16), .PULSE_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    decod_mem_seq #(.ADDR_W(4), .NUM_WORDS(12), .PULSE_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    decod_mem_seq #(.ADDR_W(4), .NUM_WORDS(16), .PULSE_LEN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Observation vector per DUT: {sel[15:0], wr, rd, ack, err, busy}
    logic [20:0] obs [3];
    assign obs[0] = {bus_a.sel, bus_a.wr_strobe, bus_a.rd_strobe, bus_a.ack, bus_a.err, bus_a.busy};
    assign obs[1] = {4'b0000, bus_b.sel, bus_b.wr_strobe, bus_b.rd_strobe, bus_b.ack, bus_b.err, bus_b.busy};
    assign obs[2] = {bus_c.sel, bus_c.wr_strobe, bus_c.rd_strobe, bus_c.ack, bus_c.err, bus_c.busy};

    function automatic int nw_of(input int d);
        return (d == 1) ? 12 : 16;
    endfunction

    function automatic int pl_of(input int d);
        case (d)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    // Expected outputs k cycles after the edge that accepted a request.
    function automatic logic [20:0] model(input int nw, input int pl, input int a,
                                          input bit w, input int k);
        logic [15:0] s;
        s = 16'd1 << a;
        if (a >= nw) begin
            if (k == 1) return {16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            return 21'd0;
        end
        if (k == 1)       return {s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        if (k <= pl + 1)  return {s, w, ~w, 1'b0, 1'b0, 1'b1};
        if (k == pl + 2)  return {s, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        return 21'd0;
    endfunction

    task automatic do_txn(input int a, input bit w);
        logic [20:0] want;
        @(negedge clk);
        req = 1'b1; we = w; addr = 4'(a);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            // Scramble the request inputs mid-transaction; they must be ignored.
            req  = 1'b0;
            we   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            for (int d = 0; d < 3; d++) begin
                want = model(nw_of(d), pl_of(d), a, w, k);
                n_tests++;
                if (obs[d] !== want) begin
                    n_fail++;
                    $display("FAIL txn dut%0d addr=%0d we=%0d k=%0d: got %h want %h",
                             d, a, w, k, obs[d], want);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs[d] !== 21'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want 0", d, obs[d]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs[d] !== 21'd0) begin
                n_fail++;
                $display("FAIL idle_no_req dut%0d: got %h want 0", d, obs[d]);
            end
        end
    endtask

    task automatic test_write_all;
        for (int a = 0; a < 16; a++) do_txn(a, 1'b1);
    endtask

    task automatic test_read_long;
        do_txn(9, 1'b0);
    endtask

    task automatic test_out_of_range;
        do_txn(13, 1'b0);
        do_txn(12, 1'b1);
    endtask

    task automatic test_reset_mid_strobe;
        logic [20:0] want;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd5;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        want = model(16, 3, 5, 1'b1, 1);
        n_tests++;
        if (obs[2] !== want) begin
            n_fail++;
            $display("FAIL rst_mid setup: got %h want %h", obs[2], want);
        end
        repeat (2) @(negedge clk);
        want = model(16, 3, 5, 1'b1, 3);
        n_tests++;
        if (obs[2] !== want) begin
            n_fail++;
            $display("FAIL rst_mid second strobe: got %h want %h", obs[2], want);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs[2] !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_mid async clear: got %h want 0", obs[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs[2] !== 21'd0) begin
                n_fail++;
                $display("FAIL rst_mid no ack cycle %0d: got %h want 0", k, obs[2]);
            end
        end
        do_txn(5, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [20:0] want;
        bit          w;
        w = 1'($urandom_range(0, 1));
        @(negedge clk);
        req = 1'b1; we = w; addr = 4'd3;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) addr = 4'd7;
            want = (k <= 4) ? model(16, 1, 3, w, k) : model(16, 1, 7, w, k - 4);
            n_tests++;
            if (obs[0] !== want) begin
                n_fail++;
                $display("FAIL b2b k=%0d: got %h want %h", k, obs[0], want);
            end
            if (k == 5) req = 1'b0;
        end
        repeat (8) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs[d][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b drain dut%0d busy: got %b want 0", d, obs[d][0]);
            end
        end
    endtask

    task automatic test_random_txn;
        for (int n = 0; n < 40; n++) do_txn(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_random_stream;
        logic prev_ack [3];
        for (int d = 0; d < 3; d++) prev_ack[d] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if ($countones(obs[d][20:5]) > 1) begin
                    n_fail++;
                    $display("FAIL onehot dut%0d cyc %0d: sel %h", d, c, obs[d][20:5]);
                end
                n_tests++;
                if (obs[d][4] && obs[d][3]) begin
                    n_fail++;
                    $display("FAIL strobe excl dut%0d cyc %0d: wr=%b rd=%b want not both",
                             d, c, obs[d][4], obs[d][3]);
                end
                n_tests++;
                if (prev_ack[d] && obs[d][2]) begin
                    n_fail++;
                    $display("FAIL ack double dut%0d cyc %0d: got 1 want 0", d, c);
                end
                prev_ack[d] = obs[d][2];
            end
            req  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
        end
        req = 1'b0;
        repeat (10) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs[d] !== 21'd0) begin
                n_fail++;
                $display("FAIL stream drain dut%0d: got %h want 0", d, obs[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_read_long();
        test_out_of_range();
        test_reset_mid_strobe();
        test_back_to_back();
        test_random_txn();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
